// File: rtl/mult_share_arb.sv
// Round-robin shared unsigned multiplier with a single-entry tagged result register.
// Optional per-requester grant counters enabled by defining MULT_ARB_STATS_EN.

module mult #(
  parameter int MD_WD = 16,
  parameter int MR_WD = 9
) (
  input  logic [MD_WD-1:0]       a_i,
  input  logic [MR_WD-1:0]       b_i,
  output logic [MD_WD+MR_WD-1:0] p_o
);
  assign p_o = {{MR_WD{1'b0}}, a_i} * {{MD_WD{1'b0}}, b_i};
endmodule

module mult_share_arb #(
  parameter int NREQ    = 4,
  parameter int MD_WD   = 16,
  parameter int MR_WD   = 9,
  parameter int MDMR_WD = MD_WD + MR_WD,
  parameter int ID_WD   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*MD_WD-1:0]   req_a,
  input  logic [NREQ*MR_WD-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_WD-1:0]        rsp_id,
  output logic [MDMR_WD-1:0]      rsp_o
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]      grant_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [ID_WD:0]   NREQ_W = (ID_WD+1)'(NREQ);
  localparam logic [ID_WD-1:0] LAST_ID = ID_WD'(NREQ - 1);

  state_t               state_q;
  logic [ID_WD-1:0]     ptr_q;
  logic [ID_WD-1:0]     rsp_id_q;
  logic [MDMR_WD-1:0]   rsp_q;

  logic                 acc;
  logic                 gnt_found;
  logic [ID_WD-1:0]     gnt_idx;
  logic [ID_WD:0]       cand;
  logic                 grant;
  logic [ID_WD-1:0]     ptr_d;
  logic [MD_WD-1:0]     sel_a;
  logic [MR_WD-1:0]     sel_b;
  logic [MDMR_WD-1:0]   prod;

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_o     = rsp_q;
  assign acc       = !rsp_valid || rsp_ready;

  // First valid index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_WD+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!gnt_found && req_valid[cand[ID_WD-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_WD-1:0];
      end
    end
  end

  assign grant     = gnt_found && acc && !rst;
  assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
  assign ptr_d     = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    sel_a = req_a[gnt_idx*MD_WD +: MD_WD];
    sel_b = req_b[gnt_idx*MR_WD +: MR_WD];
  end

  mult #(
    .MD_WD (MD_WD),
    .MR_WD (MR_WD)
  ) u_mult (
    .a_i (sel_a),
    .b_i (sel_b),
    .p_o (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      rsp_id_q <= '0;
      rsp_q    <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (grant) begin
            state_q  <= FULL;
            rsp_q    <= prod;
            rsp_id_q <= gnt_idx;
            ptr_q    <= ptr_d;
          end
        end
        FULL: begin
          if (grant) begin
            rsp_q    <= prod;
            rsp_id_q <= gnt_idx;
            ptr_q    <= ptr_d;
          end else if (rsp_ready) begin
            state_q  <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef MULT_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else if (grant && gnt_idx == ID_WD'(i) && cnt_q[i] != '1) begin
        cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed self-checking bench for mult_share_arb (NREQ=4, 16x9).
// Counter saturation test runs only when MULT_ARB_STATS_EN is defined.

module tb_mult_share_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [35:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [24:0] rsp_o;
`ifdef MULT_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int unsigned cmp_cnt = 0;
  int unsigned err_cnt = 0;

  mult_share_arb #(
    .NREQ  (4),
    .MD_WD (16),
    .MR_WD (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_o     (rsp_o)
`ifdef MULT_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lane0 0x1234*3=0x369C, lane1 0xFF*0x100=0xFF00,
  // lane2 0xABCD*0x1FF=0x156EE33, lane3 0x8000*2=0x10000
  logic [24:0] exp_p [4];
  initial begin
    exp_p[0] = 25'h000369C;
    exp_p[1] = 25'h000FF00;
    exp_p[2] = 25'h156EE33;
    exp_p[3] = 25'h0010000;
  end

  task automatic load_ops;
    req_a = {16'h8000, 16'hABCD, 16'h00FF, 16'h1234};
    req_b = {9'h002, 9'h1FF, 9'h100, 9'h003};
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    load_ops();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_hold cyc%0d: req_ready=%b rsp_valid=%b, required 0000/0", i, req_ready, rsp_valid);
      end
    end
    cmp_cnt++;
    if (rsp_id !== 2'd0 || rsp_o !== 25'd0) begin
      err_cnt++;
      $display("FAIL reset_regs: rsp_id=%0d rsp_o=%h, required 0/0", rsp_id, rsp_o);
    end
    rst = 1'b0;
    #1;
    cmp_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++;
      $display("FAIL first_grant: req_ready=%b, required 0001", req_ready);
    end
    @(posedge clk); #1;
    cmp_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_o !== exp_p[0]) begin
      err_cnt++;
      $display("FAIL first_rsp: v=%b id=%0d o=%h, required 1/0/%h", rsp_valid, rsp_id, rsp_o, exp_p[0]);
    end
    req_valid = '0;
    @(posedge clk); #1;
    cmp_cnt++;
    if (rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain_empty: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_max_operands;
    req_a[32 +: 16] = 16'hFFFF;
    req_b[18 +: 9]  = 9'h1FF;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    cmp_cnt++;
    if (req_ready !== 4'b0100) begin
      err_cnt++;
      $display("FAIL max_ready: req_ready=%b, required 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    cmp_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_o !== 25'h1FEFE01) begin
      err_cnt++;
      $display("FAIL max_product: v=%b id=%0d o=%h, required 1/2/1fefe01", rsp_valid, rsp_id, rsp_o);
    end
    @(posedge clk); #1;
    load_ops();
  endtask

  task automatic test_round_robin;
    do_reset();
    load_ops();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      cmp_cnt++;
      if (req_ready !== (4'b0001 << (k % 4))) begin
        err_cnt++;
        $display("FAIL rr_ready[%0d]: req_ready=%b, required %b", k, req_ready, 4'b0001 << (k % 4));
      end
      @(posedge clk); #1;
      cmp_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_o !== exp_p[k % 4]) begin
        err_cnt++;
        $display("FAIL rr_rsp[%0d]: v=%b id=%0d o=%h, required 1/%0d/%h", k, rsp_valid, rsp_id, rsp_o, k % 4, exp_p[k % 4]);
      end
    end
  endtask

  // Entered FULL holding id 1 with ptr at 2 and all requesters still valid.
  task automatic test_backpressure;
    rsp_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      cmp_cnt++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_o !== exp_p[1]) begin
        err_cnt++;
        $display("FAIL bp_hold[%0d]: rdy=%b v=%b id=%0d o=%h, required 0000/1/1/%h", i, req_ready, rsp_valid, rsp_id, rsp_o, exp_p[1]);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    cmp_cnt++;
    if (req_ready !== 4'b0100) begin
      err_cnt++;
      $display("FAIL bp_release_ready: req_ready=%b, required 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    cmp_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_o !== exp_p[2]) begin
      err_cnt++;
      $display("FAIL bp_refill: v=%b id=%0d o=%h, required 1/2/%h", rsp_valid, rsp_id, rsp_o, exp_p[2]);
    end
    @(posedge clk); #1;
    cmp_cnt++;
    if (rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_empty: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  // ptr is 3 here: grants to 3 wrap ptr to 0, and the search still finds 3.
  task automatic test_single_requester;
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      cmp_cnt++;
      if (req_ready !== 4'b1000) begin
        err_cnt++;
        $display("FAIL single_ready[%0d]: req_ready=%b, required 1000", i, req_ready);
      end
      @(posedge clk); #1;
      cmp_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_o !== exp_p[3]) begin
        err_cnt++;
        $display("FAIL single_rsp[%0d]: v=%b id=%0d o=%h, required 1/3/%h", i, rsp_valid, rsp_id, rsp_o, exp_p[3]);
      end
    end
    req_valid = 4'b1111;
    #1;
    cmp_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++;
      $display("FAIL ptr_wrap: req_ready=%b, required 0001", req_ready);
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_while_full;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    cmp_cnt++;
    if (req_ready !== 4'b0010) begin
      err_cnt++;
      $display("FAIL rf_grant: req_ready=%b, required 0010", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if (req_ready !== 4'b0000) begin
      err_cnt++;
      $display("FAIL rf_rst_ready: req_ready=%b, required 0000", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    #1;
    cmp_cnt++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_o !== 25'd0) begin
      err_cnt++;
      $display("FAIL rf_cleared: v=%b id=%0d o=%h, required 0/0/0", rsp_valid, rsp_id, rsp_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (rsp_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL rf_no_rsp[%0d]: rsp_valid=%b, required 0", i, rsp_valid);
      end
    end
    req_valid = 4'b1111;
    #1;
    cmp_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++;
      $display("FAIL rf_ptr0: req_ready=%b, required 0001", req_ready);
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

`ifdef MULT_ARB_STATS_EN
  task automatic test_stats_saturate;
    do_reset();
    cmp_cnt++;
    if (grant_cnt !== 64'd0) begin
      err_cnt++;
      $display("FAIL stats_reset: grant_cnt=%h, required 0", grant_cnt);
    end
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    cmp_cnt++;
    if (grant_cnt[15:0] !== 16'hFFFF || grant_cnt[63:16] !== 48'd0) begin
      err_cnt++;
      $display("FAIL stats_saturate: grant_cnt=%h, required 000000000000ffff", grant_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_max_operands();
    test_round_robin();
    test_backpressure();
    test_single_requester();
    test_reset_while_full();
`ifdef MULT_ARB_STATS_EN
    test_stats_saturate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
